// File: rtl/slc3_mem_bridge_pkg.sv
// Shared types and constants for the SLC3 memory/IO bridge.
package slc3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [15:0] MMIO_ADDR_DEFAULT = 16'hFFFF;
  localparam int          WAIT_W            = 4;

endpackage

// File: rtl/slc3_mem_bridge_if.sv
// ISDU/datapath-side request bus plus the SRAM-side signals driven by the bridge.
interface slc3_mem_bridge_if;
  logic        MIO_EN;
  logic        MEM_WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] sram_rdata;
  logic [15:0] MDR_In;
  logic        R;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_ce;
  logic        sram_we;

  modport master (
    output MIO_EN, MEM_WE, MAR, MDR, sram_rdata,
    input  MDR_In, R, sram_addr, sram_wdata, sram_ce, sram_we
  );

  modport slave (
    input  MIO_EN, MEM_WE, MAR, MDR, sram_rdata,
    output MDR_In, R, sram_addr, sram_wdata, sram_ce, sram_we
  );
endinterface

// File: rtl/slc3_mem_bridge_sync_ff.sv
// Multi-flop synchroniser for an asynchronous bus (board switches).
module sync_ff #(
  parameter int N      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/slc3_mem_bridge.sv
// SLC3 memory bridge: SRAM access with programmable wait states and one
// memory-mapped switch/hex I/O address.
module slc3_mem_bridge
  import slc3_pkg::*;
#(
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  slc3_mem_bridge_if.slave    bus,
  input  logic [15:0]         SW,
  output logic [15:0]         HEX_DATA
);

  mem_state_t        state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_write;
  logic [15:0]       sw_sync;
  logic [15:0]       mdr_in;
  logic [15:0]       hex_data;
  logic [15:0]       sram_addr;
  logic [15:0]       sram_wdata;
  logic              sram_ce;
  logic              sram_we;
  logic              ready;
  logic              req;
  logic              is_mmio;

  sync_ff #(.N(16), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clk (Clk),
    .rst (Reset),
    .d   (SW),
    .q   (sw_sync)
  );

  assign req     = bus.MIO_EN | bus.MEM_WE;
  assign is_mmio = (bus.MAR == MMIO_ADDR);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = is_mmio ? DONE : WAIT;
      WAIT:    if (wait_cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == DONE);
  end

  // Datapath registers; a simultaneous read+write request is treated as a write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt   <= '0;
      is_write   <= 1'b0;
      mdr_in     <= '0;
      hex_data   <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            sram_addr  <= bus.MAR;
            sram_wdata <= bus.MDR;
            is_write   <= bus.MEM_WE;
            if (is_mmio) begin
              if (bus.MEM_WE) hex_data <= bus.MDR;
              else            mdr_in   <= sw_sync;
            end else begin
              wait_cnt <= WAIT_W'(WAIT_STATES);
              sram_ce  <= 1'b1;
              sram_we  <= bus.MEM_WE;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            sram_ce <= 1'b0;
            sram_we <= 1'b0;
            if (!is_write) mdr_in <= bus.sram_rdata;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.MDR_In     = mdr_in;
  assign bus.R          = ready;
  assign bus.sram_addr  = sram_addr;
  assign bus.sram_wdata = sram_wdata;
  assign bus.sram_ce    = sram_ce;
  assign bus.sram_we    = sram_we;
  assign HEX_DATA       = hex_data;

endmodule
